// File: rtl/iq_interleave.sv
// Serializes one joined I/Q sample into two consecutive words on a single stream.
// Word order is set by Q_FIRST; tlast marks the second word of each pair.
module iq_interleave #(
  parameter int unsigned WIDTH   = 16,
  parameter bit          Q_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] input_i_tdata,
  input  logic [WIDTH-1:0] input_q_tdata,
  input  logic             input_tvalid,
  output logic             input_tready,
  output logic [WIDTH-1:0] output_tdata,
  output logic             output_tvalid,
  input  logic             output_tready,
  output logic             output_tlast,
  output logic             output_tuser
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             out_user_q, out_user_d;
  logic [WIDTH-1:0] pend_data_q, pend_data_d;

  logic [WIDTH-1:0] first_word_s;
  logic [WIDTH-1:0] second_word_s;
  logic             first_user_s;
  logic             accept_s;

  assign first_word_s  = Q_FIRST ? input_q_tdata : input_i_tdata;
  assign second_word_s = Q_FIRST ? input_i_tdata : input_q_tdata;
  assign first_user_s  = Q_FIRST ? 1'b1 : 1'b0;

  // Ready looks through to output_tready in SECOND so a new pair can load
  // on the same edge the second word drains, giving one word per cycle.
  assign input_tready = !rst && ((state_q == IDLE) ||
                                 ((state_q == SECOND) && output_tready));
  assign accept_s     = input_tvalid && input_tready;

  // Next-state and output-register update
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_user_d  = out_user_q;
    pend_data_d = pend_data_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          out_data_d  = first_word_s;
          out_user_d  = first_user_s;
          out_last_d  = 1'b0;
          out_valid_d = 1'b1;
          pend_data_d = second_word_s;
          state_d     = FIRST;
        end else begin
          out_valid_d = 1'b0;
        end
      end
      FIRST: begin
        if (output_tready) begin
          out_data_d = pend_data_q;
          out_last_d = 1'b1;
          out_user_d = ~out_user_q;
          state_d    = SECOND;
        end else begin
          state_d = FIRST;
        end
      end
      SECOND: begin
        if (output_tready && accept_s) begin
          out_data_d  = first_word_s;
          out_user_d  = first_user_s;
          out_last_d  = 1'b0;
          out_valid_d = 1'b1;
          pend_data_d = second_word_s;
          state_d     = FIRST;
        end else if (output_tready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = SECOND;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any half-sent pair
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_user_q  <= 1'b0;
      pend_data_q <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_user_q  <= out_user_d;
      pend_data_q <= pend_data_d;
    end
  end

  assign output_tdata  = out_data_q;
  assign output_tvalid = out_valid_q;
  assign output_tlast  = out_last_q;
  assign output_tuser  = out_user_q;

endmodule

// File: tb/tb_iq_interleave.sv
// Directed self-checking bench for iq_interleave, both word orders.
module tb_iq_interleave;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_i, in_q;
  logic        in_valid;
  logic        out_ready;

  logic        rdy0, rdy1;
  logic [15:0] data0, data1;
  logic        valid0, valid1, last0, last1, user0, user1;

  int checks = 0;
  int errors = 0;

  // observed {tvalid, tlast, tuser, tdata}
  logic [18:0] obs0, obs1, exp;
  assign obs0 = {valid0, last0, user0, data0};
  assign obs1 = {valid1, last1, user1, data1};

  always #5 clk = ~clk;

  iq_interleave #(.WIDTH(16), .Q_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .input_i_tdata(in_i), .input_q_tdata(in_q),
    .input_tvalid(in_valid), .input_tready(rdy0),
    .output_tdata(data0), .output_tvalid(valid0), .output_tready(out_ready),
    .output_tlast(last0), .output_tuser(user0)
  );

  iq_interleave #(.WIDTH(16), .Q_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst),
    .input_i_tdata(in_i), .input_q_tdata(in_q),
    .input_tvalid(in_valid), .input_tready(rdy1),
    .output_tdata(data1), .output_tvalid(valid1), .output_tready(out_ready),
    .output_tlast(last1), .output_tuser(user1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_i = 16'h0; in_q = 16'h0; out_ready = 1'b1;
    step(); step();
    exp = 19'h0;
    checks++; if (obs0 !== exp) begin errors++; $display("FAIL reset_out got %h want %h", obs0, exp); end
    checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", rdy0); end
    rst = 1'b0;
    #1;
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL idle_ready got %b want 1", rdy0); end
  endtask

  task automatic test_single();
    in_i = 16'h1234; in_q = 16'hABCD; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    exp = {1'b1, 1'b0, 1'b0, 16'h1234};
    checks++; if (obs0 !== exp) begin errors++; $display("FAIL single_first got %h want %h", obs0, exp); end
    checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL single_first_ready got %b want 0", rdy0); end
    step();
    exp = {1'b1, 1'b1, 1'b1, 16'hABCD};
    checks++; if (obs0 !== exp) begin errors++; $display("FAIL single_second got %h want %h", obs0, exp); end
    step();
    checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL single_idle got %b want 0", valid0); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] idx;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      idx = 16'(j / 2 + 1);
      if (j % 2 == 0) begin
        in_i = idx; in_q = 16'h1000 + idx;
      end
      #1;
      checks++; if (rdy0 !== (j % 2 == 0)) begin errors++; $display("FAIL b2b_ready[%0d] got %b want %b", j, rdy0, (j % 2 == 0)); end
      step();
      exp = (j % 2 == 0) ? {1'b1, 1'b0, 1'b0, idx} : {1'b1, 1'b1, 1'b1, 16'h1000 + idx};
      checks++; if (obs0 !== exp) begin errors++; $display("FAIL b2b_word[%0d] got %h want %h", j, obs0, exp); end
    end
    in_valid = 1'b0;
    step();
    checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b want 0", valid0); end
  endtask

  task automatic test_backpressure();
    in_i = 16'h0001; in_q = 16'h1001; in_valid = 1'b1; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_i = 16'h0bad; in_q = 16'h0bad;
    exp = {1'b1, 1'b0, 1'b0, 16'h0001};
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (obs0 !== exp) begin errors++; $display("FAIL bp_hold[%0d] got %h want %h", k, obs0, exp); end
      checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %b want 0", k, rdy0); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    exp = {1'b1, 1'b1, 1'b1, 16'h1001};
    checks++; if (obs0 !== exp) begin errors++; $display("FAIL bp_release got %h want %h", obs0, exp); end
    step();
    checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL bp_idle got %b want 0", valid0); end
  endtask

  task automatic test_q_first();
    in_i = 16'h5555; in_q = 16'hAAAA; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    exp = {1'b1, 1'b0, 1'b1, 16'hAAAA};
    checks++; if (obs1 !== exp) begin errors++; $display("FAIL qfirst_first got %h want %h", obs1, exp); end
    step();
    exp = {1'b1, 1'b1, 1'b0, 16'h5555};
    checks++; if (obs1 !== exp) begin errors++; $display("FAIL qfirst_second got %h want %h", obs1, exp); end
    step();
    checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL qfirst_idle got %b want 0", valid1); end
  endtask

  task automatic test_reset_mid_pair();
    in_i = 16'h1234; in_q = 16'hABCD; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b want 0", rdy0); end
    step();
    rst = 1'b0;
    exp = 19'h0;
    checks++; if (obs0 !== exp) begin errors++; $display("FAIL midrst_cleared got %h want %h", obs0, exp); end
    step();
    checks++; if (obs0 !== exp) begin errors++; $display("FAIL midrst_no_stale got %h want %h", obs0, exp); end
    in_i = 16'h0007; in_q = 16'h0008; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    exp = {1'b1, 1'b0, 1'b0, 16'h0007};
    checks++; if (obs0 !== exp) begin errors++; $display("FAIL midrst_new_first got %h want %h", obs0, exp); end
    step();
    exp = {1'b1, 1'b1, 1'b1, 16'h0008};
    checks++; if (obs0 !== exp) begin errors++; $display("FAIL midrst_new_second got %h want %h", obs0, exp); end
    step();
    checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL midrst_idle got %b want 0", valid0); end
  endtask

  task automatic test_gapped();
    logic [15:0] iv [3];
    logic [15:0] qv [3];
    iv[0] = 16'h00A1; qv[0] = 16'h0B01;
    iv[1] = 16'hFFFF; qv[1] = 16'h0000;
    iv[2] = 16'h8000; qv[2] = 16'h7FFF;
    out_ready = 1'b1;
    for (int p = 0; p < 3; p++) begin
      in_i = iv[p]; in_q = qv[p]; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      exp = {1'b1, 1'b0, 1'b0, iv[p]};
      checks++; if (obs0 !== exp) begin errors++; $display("FAIL gap_first[%0d] got %h want %h", p, obs0, exp); end
      step();
      exp = {1'b1, 1'b1, 1'b1, qv[p]};
      checks++; if (obs0 !== exp) begin errors++; $display("FAIL gap_second[%0d] got %h want %h", p, obs0, exp); end
      for (int g = 0; g < 2; g++) begin
        step();
        checks++; if ({valid0, last0} !== 2'b00) begin errors++; $display("FAIL gap_idle[%0d.%0d] got %b want 00", p, g, {valid0, last0}); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_q_first();
    test_reset_mid_pair();
    test_gapped();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
